// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scancode parser producing make/break events into a show-ahead FIFO.
// Also tracks a held-key bitmap for a table of game keys.
module ps2_key_event_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NUM_KEYS = 8,
    // Entry i = {ext, code} in bits [9i+8:9i]; msb->lsb up, down, left, right, W, A, S, D
    parameter logic [9*NUM_KEYS-1:0] KEY_TABLE = {9'h175, 9'h172, 9'h16B, 9'h174,
                                                  9'h01D, 9'h01C, 9'h01B, 9'h023},
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_en,
    input  logic [7:0]                        key_data,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [7:0]                        ev_code,
    output logic                              ev_ext,
    output logic                              ev_make,
    output logic [4:0]                        ev_key,
    output logic [NUM_KEYS-1:0]               held,
    output logic [7:0]                        keycode,
    output logic                              key_make,
    output logic                              key_ext,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   ev_count,
    output logic                              overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    state_e              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic                fire, fire_ext, fire_make;
    logic                hit, already;
    logic [4:0]          idx;
    logic [NUM_KEYS-1:0] mask;
    logic [NUM_KEYS-1:0] held_q;
    logic                push_req, do_push, pop, full;
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       count_q;
    logic [14:0]         mem_q [FIFO_DEPTH];
    logic [7:0]          keycode_q;
    logic                key_make_q, key_ext_q, overflow_q;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        fire      = 1'b0;
        fire_ext  = 1'b0;
        fire_make = 1'b0;
        if (key_en) begin
            unique case (state_q)
                StIdle: begin
                    if (key_data == 8'hE0) state_d = StExt;
                    else if (key_data == 8'hF0) state_d = StBrk;
                    else if (key_data == 8'hE1) begin
                        state_d = StSkip;
                        skip_d  = 3'd7;
                    end else if (!(key_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE,
                                                    8'hFF})) begin
                        fire      = 1'b1;
                        fire_make = 1'b1;
                    end
                end
                StExt: begin
                    if (key_data == 8'hF0) state_d = StExtBrk;
                    else if (key_data == 8'hE1) begin
                        state_d = StSkip;
                        skip_d  = 3'd7;
                    end else if (key_data != 8'hE0) begin
                        fire      = 1'b1;
                        fire_ext  = 1'b1;
                        fire_make = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StBrk: begin
                    if (key_data == 8'hE0) state_d = StExtBrk;
                    else if (key_data != 8'hF0) begin
                        fire    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StExtBrk: begin
                    if (key_data != 8'hF0 && key_data != 8'hE0) begin
                        fire     = 1'b1;
                        fire_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StSkip: begin
                    if (skip_q == 3'd1) state_d = StIdle;
                    else skip_d = skip_q - 3'd1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        already = 1'b0;
        idx     = 5'h1F;
        mask    = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_TABLE[9*i +: 9] == {fire_ext, key_data}) begin
                hit     = 1'b1;
                already = held_q[i];
                idx     = 5'(i);
                mask    = '0;
                mask[i] = 1'b1;
            end
        end
    end

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = ev_valid & ev_ready;
    assign push_req = fire & ~(SUPPRESS_REPEAT & fire_make & hit & already);
    assign do_push  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            skip_q     <= '0;
            held_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            keycode_q  <= '0;
            key_make_q <= 1'b0;
            key_ext_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            if (fire) begin
                keycode_q  <= key_data;
                key_make_q <= fire_make;
                key_ext_q  <= fire_ext;
                if (hit) held_q <= fire_make ? (held_q | mask) : (held_q & ~mask);
            end
            if (push_req && full && !pop) overflow_q <= 1'b1;
            if (do_push) begin
                mem_q[wr_q] <= {key_data, fire_ext, fire_make, idx};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (do_push && !pop) count_q <= count_q + 1'b1;
            else if (!do_push && pop) count_q <= count_q - 1'b1;
        end
    end

    assign {ev_code, ev_ext, ev_make, ev_key} = mem_q[rd_q];
    assign ev_valid = (count_q != '0);
    assign ev_count = count_q;
    assign held     = held_q;
    assign keycode  = keycode_q;
    assign key_make = key_make_q;
    assign key_ext  = key_ext_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder; a second instance runs with repeat suppression off.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_en = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       ev_ready = 1'b0;

    logic       ev_valid, ev_ext, ev_make, key_make, key_ext, overflow;
    logic [7:0] ev_code, keycode, held;
    logic [4:0] ev_key;
    logic [3:0] ev_count;

    logic       nr_valid, nr_ext, nr_make, nr_kmake, nr_kext, nr_overflow;
    logic [7:0] nr_code, nr_keycode, nr_held;
    logic [4:0] nr_key;
    logic [3:0] nr_count;

    int passed = 0;
    int total = 0;

    always #10 clk = ~clk;

    ps2_key_event_decoder dut (
        .clk(clk), .reset(reset), .key_en(key_en), .key_data(key_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_make(ev_make), .ev_key(ev_key), .held(held), .keycode(keycode),
        .key_make(key_make), .key_ext(key_ext), .ev_count(ev_count), .overflow(overflow)
    );

    ps2_key_event_decoder #(.SUPPRESS_REPEAT(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .key_en(key_en), .key_data(key_data),
        .ev_valid(nr_valid), .ev_ready(ev_ready), .ev_code(nr_code), .ev_ext(nr_ext),
        .ev_make(nr_make), .ev_key(nr_key), .held(nr_held), .keycode(nr_keycode),
        .key_make(nr_kmake), .key_ext(nr_kext), .ev_count(nr_count), .overflow(nr_overflow)
    );

    task automatic do_reset();
        reset = 1'b1;
        key_en = 1'b0;
        ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was sampled.
    task automatic send(input logic [7:0] b);
        key_en = 1'b1;
        key_data = b;
        @(posedge clk);
        #1 key_en = 1'b0;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ev_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ev_valid); else passed++;
        total++; if (ev_count !== 4'd0) $display("FAIL rst_count got %0d want 0", ev_count); else passed++;
        total++; if (held !== 8'h00) $display("FAIL rst_held got %h want 00", held); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else passed++;
        total++; if (ev_key !== 5'h00) $display("FAIL rst_ev_key got %h want 00", ev_key); else passed++;
        total++; if (keycode !== 8'h00) $display("FAIL rst_keycode got %h want 00", keycode); else passed++;
    endtask

    task automatic test_make();
        do_reset();
        key_en = 1'b1;
        key_data = 8'h1D;
        #1;
        total++; if (ev_valid !== 1'b0) $display("FAIL mk_early_valid got %b want 0", ev_valid); else passed++;
        @(posedge clk);
        #1 key_en = 1'b0;
        total++; if (ev_valid !== 1'b1) $display("FAIL mk_valid got %b want 1", ev_valid); else passed++;
        total++; if (ev_code !== 8'h1D) $display("FAIL mk_code got %h want 1d", ev_code); else passed++;
        total++; if ({ev_ext, ev_make} !== 2'b01) $display("FAIL mk_flags got %b want 01", {ev_ext, ev_make}); else passed++;
        total++; if (ev_key !== 5'd3) $display("FAIL mk_key got %0d want 3", ev_key); else passed++;
        total++; if (held !== 8'h08) $display("FAIL mk_held got %h want 08", held); else passed++;
        total++; if ({keycode, key_make, key_ext} !== {8'h1D, 2'b10}) $display("FAIL mk_debug got %h want %h", {keycode, key_make, key_ext}, {8'h1D, 2'b10}); else passed++;
        pop_one();
        total++; if (ev_count !== 4'd0) $display("FAIL mk_pop_count got %0d want 0", ev_count); else passed++;
        send(8'hF0);
        send(8'h1D);
        total++; if (held !== 8'h00) $display("FAIL mk_release_held got %h want 00", held); else passed++;
        total++; if ({ev_code, ev_make} !== {8'h1D, 1'b0}) $display("FAIL mk_break got %h want %h", {ev_code, ev_make}, {8'h1D, 1'b0}); else passed++;
    endtask

    task automatic test_ext();
        do_reset();
        send(8'hE0);
        send(8'h75);
        total++; if (held !== 8'h80) $display("FAIL ext_held_make got %h want 80", held); else passed++;
        total++; if ({ev_code, ev_ext, ev_make, ev_key} !== {8'h75, 2'b11, 5'd7}) $display("FAIL ext_make_ev got %h want %h", {ev_code, ev_ext, ev_make, ev_key}, {8'h75, 2'b11, 5'd7}); else passed++;
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        total++; if (held !== 8'h00) $display("FAIL ext_held_break got %h want 00", held); else passed++;
        total++; if (ev_count !== 4'd2) $display("FAIL ext_count got %0d want 2", ev_count); else passed++;
        pop_one();
        total++; if ({ev_code, ev_ext, ev_make, ev_key} !== {8'h75, 2'b10, 5'd7}) $display("FAIL ext_break_ev got %h want %h", {ev_code, ev_ext, ev_make, ev_key}, {8'h75, 2'b10, 5'd7}); else passed++;
        total++; if (key_ext !== 1'b1 || key_make !== 1'b0) $display("FAIL ext_debug got %b%b want 10", key_ext, key_make); else passed++;
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h1C);
        total++; if (ev_count !== 4'd1) $display("FAIL rep_count got %0d want 1", ev_count); else passed++;
        total++; if (nr_count !== 4'd5) $display("FAIL rep_count_nosup got %0d want 5", nr_count); else passed++;
        total++; if (held !== 8'h04) $display("FAIL rep_held got %h want 04", held); else passed++;
        total++; if (keycode !== 8'h1C) $display("FAIL rep_keycode got %h want 1c", keycode); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1E, 8'h21, 8'h22};
        do_reset();
        for (int i = 0; i < 9; i++) send(codes[i]);
        total++; if (ev_count !== 4'd8) $display("FAIL ovf_count got %0d want 8", ev_count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        total++; if (held !== 8'h00) $display("FAIL ovf_held got %h want 00", held); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if ({ev_code, ev_key} !== {codes[i], 5'h1F}) $display("FAIL ovf_drain%0d got %h want %h", i, {ev_code, ev_key}, {codes[i], 5'h1F}); else passed++;
            pop_one();
        end
        total++; if (ev_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", ev_valid); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [8];
        codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1E, 8'h21};
        do_reset();
        for (int i = 0; i < 8; i++) send(codes[i]);
        total++; if (ev_count !== 4'd8) $display("FAIL b2b_full got %0d want 8", ev_count); else passed++;
        key_en = 1'b1;
        key_data = 8'h2A;
        ev_ready = 1'b1;
        @(posedge clk);
        #1 key_en = 1'b0;
        ev_ready = 1'b0;
        total++; if (ev_count !== 4'd8) $display("FAIL b2b_count got %0d want 8", ev_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b want 0", overflow); else passed++;
        total++; if (ev_code !== 8'h16) $display("FAIL b2b_head got %h want 16", ev_code); else passed++;
        for (int i = 0; i < 7; i++) pop_one();
        total++; if ({ev_count, ev_code} !== {4'd1, 8'h2A}) $display("FAIL b2b_tail got %h want %h", {ev_count, ev_code}, {4'd1, 8'h2A}); else passed++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        for (int i = 0; i < 8; i++) send(seq[i]);
        send(8'hFA);
        total++; if (ev_count !== 4'd0) $display("FAIL pause_none got %0d want 0", ev_count); else passed++;
        send(8'h23);
        total++; if (ev_count !== 4'd1) $display("FAIL pause_count got %0d want 1", ev_count); else passed++;
        total++; if ({ev_code, ev_make, ev_key} !== {8'h23, 1'b1, 5'd0}) $display("FAIL pause_ev got %h want %h", {ev_code, ev_make, ev_key}, {8'h23, 1'b1, 5'd0}); else passed++;
        total++; if (held !== 8'h01) $display("FAIL pause_held got %h want 01", held); else passed++;
        send(8'hF0);
        do_reset();
        send(8'h1D);
        total++; if ({ev_code, ev_make, ev_key} !== {8'h1D, 1'b1, 5'd3}) $display("FAIL rst_partial got %h want %h", {ev_code, ev_make, ev_key}, {8'h1D, 1'b1, 5'd3}); else passed++;
        total++; if (held !== 8'h08) $display("FAIL rst_partial_held got %h want 08", held); else passed++;
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext();
        test_typematic();
        test_overflow();
        test_back_to_back();
        test_pause();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
